mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between the instruction-fetch stage (read-only) and the load/store stage (read/write).
- Each access runs as one transaction: latch the request, hold it on the memory port until the memory acknowledges, then return the data.
- Ties are broken round-robin. A wait-cycle watchdog converts a hung memory access into an error response.
- Sits between the fetch/memory pipeline stages and the memory wrapper, and drives the pipeline stall inputs.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Fixed at 32; strobe width is DATA_W/8.
- WAIT_MAX, 255, maximum cycles mem_req may stay high without mem_ready before abort. Must be ≥1.
- NOP_INSN, 32'h0000_0013, instruction data returned on a fetch error (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_done  out  1  one-cycle response pulse to fetch.
- if_rdata  out  DATA_W  fetched instruction; valid while if_done is high.
- if_err  out  1  fetch timed out; valid with if_done.
- d_req  in  1  data request; held with its fields until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_wstrb  in  4  store byte enables.
- d_done  out  1  one-cycle response pulse to the load/store stage.
- d_rdata  out  DATA_W  load data; valid with d_done.
- d_err  out  1  data access timed out; valid with d_done.
- if_stall  out  1  high when if_req=1 and if_done=0.
- d_stall  out  1  high when d_req=1 and d_done=0.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  ADDR_W  memory address, registered.
- mem_wdata  out  DATA_W  memory write data, registered.
- mem_wstrb  out  4  memory byte enables, registered. 0 for reads.
- mem_ready  in  1  memory accepts the access and returns data this cycle.
- mem_rdata  in  DATA_W  read data; valid when mem_ready=1.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, RESP. Register last_gnt: 0 = I, 1 = D.
- Reset (rst_n=0, asynchronous), all immediate:
  - state=IDLE, last_gnt=1, wait counter=0.
  - mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb = 0.
  - if_done, d_done, if_err, d_err = 0; if_rdata, d_rdata = 0.
  - A transaction in flight is dropped silently and no done pulse is issued. The memory must tolerate mem_req falling without mem_ready.
- IDLE:
  - Only if_req → BUSY_I.
  - Only d_req → BUSY_D.
  - Both → grant the side opposite last_gnt.
  - On grant, register mem_addr/mem_we/mem_wdata/mem_wstrb from the winner, set mem_req=1, set last_gnt=winner, clear the counter.
  - A fetch grant forces mem_we=0 and mem_wstrb=0.
- BUSY_x:
  - mem_req stays high and all mem_* fields stay stable.
  - When mem_ready=1: capture mem_rdata into x_rdata, set x_err=0, drop mem_req/mem_we/mem_wstrb to 0, → RESP with x_done=1.
  - When mem_ready=0: increment the counter. When the counter reaches WAIT_MAX, abort: drop mem_req, → RESP with x_done=1, x_err=1. x_rdata = NOP_INSN for fetch, 0 for data.
  - mem_ready is ignored in IDLE and RESP.
- RESP:
  - Lasts exactly one cycle, with the done pulse and its data/err. No grant is made in this cycle.
  - Requesters update or drop their req at the same edge. Then → IDLE.
- Latency: request seen at edge 0 → mem_req high after edge 0. With mem_ready in that cycle, done is high after edge 1. Back-to-back, zero-wait throughput is one access per 3 cycles.
- Rdata and err registers hold their value until the next completion for that side.
- Requester changes to addr/data while its request is pending are ignored; fields are latched at grant.
- Counter width is clog2(WAIT_MAX+1) and it never wraps.
- Stall outputs are combinational from req and done. Stall is 0 in the done cycle.

Decomposition:
- Shared cpu package:
  - state enum (IDLE, BUSY_I, BUSY_D, RESP);
  - GNT_I/GNT_D constants;
  - NOP_INSN constant, shared with the decode-flush logic.
- No sub-module. The watchdog counter is inline.

Test Plan:
- Reset mid-BUSY_D (rst_n low at an arbitrary phase) → mem_req=0 immediately, no d_done; after release, state IDLE and last_gnt=D.
- Single fetch to if_addr=0x0000_0040, mem_ready in the first mem_req cycle, mem_rdata=0x0000_0093 → if_done one cycle after, if_rdata=0x0000_0093, if_err=0, mem_we=0.
- if_req and d_req rise together from reset, store d_addr=0x100, d_wdata=0xDEADBEEF, d_wstrb=4'b0011 → fetch granted first, then the store. mem_wstrb=0011 and mem_wdata=0xDEADBEEF during BUSY_D.
- Both requesting continuously for 8 transactions → grants strictly alternate I,D,I,D…; no done before its mem_ready.
- Fetch with mem_ready held low, WAIT_MAX=4 → mem_req high exactly 5 cycles, then if_done=1, if_err=1, if_rdata=0x0000_0013.
- Load with mem_ready arriving after 3 wait cycles, mem_rdata changing every cycle → d_rdata equals the value present in the mem_ready cycle; d_stall high from d_req rise until the d_done cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared arbiter states, grant encodings and the fetch-error NOP
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;
    localparam logic [31:0] NOP_INSN_DEF = 32'h0000_0013;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between fetch and load/store, with a hang watchdog
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WAIT_MAX = 255,
    parameter logic [DATA_W-1:0] NOP_INSN = NOP_INSN_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              if_stall,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    state_e            state_q;
    logic              last_gnt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mem_req_q, mem_we_q, if_done_q, d_done_q, if_err_q, d_err_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;
    logic [3:0]        mem_wstrb_q;
    logic              win_d;
    logic              hung;

    // data wins when it is alone or when fetch had the previous grant
    assign win_d = d_req && (!if_req || last_gnt_q == GNT_I);
    assign hung = cnt_q == CNT_W'(WAIT_MAX);

    // arbitration FSM: grant, hold the port until ready or watchdog expiry, then one response cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_gnt_q  <= GNT_D;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            if_err_q    <= 1'b0;
            d_err_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            case (state_q)
                IDLE: if (if_req || d_req) begin
                    state_q     <= win_d ? BUSY_D : BUSY_I;
                    last_gnt_q  <= win_d ? GNT_D : GNT_I;
                    cnt_q       <= '0;
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= win_d && d_we;
                    mem_addr_q  <= win_d ? d_addr : if_addr;
                    mem_wdata_q <= win_d ? d_wdata : '0;
                    mem_wstrb_q <= win_d ? d_wstrb : 4'b0;
                end
                BUSY_I, BUSY_D: if (mem_ready || hung) begin
                    state_q   <= RESP;
                    mem_req_q <= 1'b0;
                    if (mem_ready) begin
                        mem_we_q    <= 1'b0;
                        mem_wstrb_q <= 4'b0;
                    end
                    if (state_q == BUSY_I) begin
                        if_done_q  <= 1'b1;
                        if_err_q   <= !mem_ready;
                        if_rdata_q <= mem_ready ? mem_rdata : NOP_INSN;
                    end else begin
                        d_done_q  <= 1'b1;
                        d_err_q   <= !mem_ready;
                        d_rdata_q <= mem_ready ? mem_rdata : '0;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign if_err    = if_err_q;
    assign d_err     = d_err_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_stall  = if_req && !if_done_q;
    assign d_stall   = d_req && !d_done_q;
endmodule
